demux_1x4_reg: RTL and testbench



---
 rtl/demux_pkg.sv | 18 +
 rtl/demux_1x4_reg_if.sv | 37 +++
 rtl/demux_lane.sv | 45 ++++
 rtl/demux_1x4_reg.sv | 96 +++++++++
 tb/tb_demux_1x4_reg.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/demux_pkg.sv
// Shared constants, lane state encoding and slice helper for the 1:4 registered demux.
// Imported by the demux interface, lane register and top level.
package demux_pkg;

    localparam int LANES = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } lane_state_e;

    // Bit offset of lane k inside the packed out_data bus.
    function automatic int lane_off(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/demux_1x4_reg_if.sv
// Handshake bundle between the single input stream and the four output lanes.
// slave = demux side, master = producer/consumer side.
interface demux_1x4_reg_if
    import demux_pkg::*;
#(
    parameter int W = 4
);

    logic                 in_valid;
    logic                 in_ready;
    logic [W-1:0]         in_data;
    logic [SEL_W-1:0]     in_sel;
    logic [LANES-1:0]     out_valid;
    logic [LANES-1:0]     out_ready;
    logic [LANES*W-1:0]   out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_sel,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output in_sel,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

endinterface

// File: rtl/demux_lane.sv
// One-deep output register for a single demux lane: load wins over drain.
// Latency 1 cycle load->valid; holds data while drain_i (consumer ready) is low.
module demux_lane
    import demux_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         drain_i,
    input  logic [W-1:0] din_i,
    output logic         vld_o,
    output logic [W-1:0] dat_o
);

    lane_state_e  state_q, state_d;
    logic [W-1:0] data_q, data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // A load in the same cycle as a drain keeps the lane FULL with the new word.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load_i) begin
            state_d = FULL;
            data_d  = din_i;
        end else if (state_q == FULL && drain_i) begin
            state_d = EMPTY;
        end
    end

    assign vld_o = (state_q == FULL);
    assign dat_o = data_q;

endmodule

// File: rtl/demux_1x4_reg.sv
// Registered 1:4 demux: routes the input word to the selected lane register.
// Latency 1 cycle accept->out_valid; in_ready drops only when the selected lane is full and stalled.
// Optional DEMUX_RR_EN: in_sel ignored, lane chosen by a round-robin pointer exposed on rr_ptr.
module demux_1x4_reg
    import demux_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux_1x4_reg_if.slave       bus,
`ifdef DEMUX_RR_EN
    output logic [SEL_W-1:0]     rr_ptr,
`endif
    output logic [CNT_W-1:0]     acc_cnt
);

    logic [SEL_W-1:0]   eff_sel;
    logic               accept;
    logic [LANES-1:0]   lane_load;
    logic [LANES-1:0]   lane_vld;
    logic [LANES*W-1:0] lane_dat;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

`ifdef DEMUX_RR_EN
    logic [SEL_W-1:0]   ptr_q, ptr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = ptr_q + SEL_W'(1);
        end
    end

    assign eff_sel = ptr_q;
    assign rr_ptr  = ptr_q;
`else
    assign eff_sel = bus.in_sel;
`endif

    // Never depends on in_valid, so a producer may wait on in_ready before asserting valid.
    assign bus.in_ready = ~lane_vld[eff_sel] | bus.out_ready[eff_sel];
    assign accept       = bus.in_valid & bus.in_ready;

    always_comb begin
        lane_load = '0;
        if (accept) begin
            lane_load[eff_sel] = 1'b1;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        demux_lane #(
            .W (W)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (lane_load[k]),
            .drain_i (bus.out_ready[k]),
            .din_i   (bus.in_data),
            .vld_o   (lane_vld[k]),
            .dat_o   (lane_dat[lane_off(k, W) +: W])
        );
    end

    assign bus.out_valid = lane_vld;
    assign bus.out_data  = lane_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Free-running modulo 2^CNT_W count of accepted words.
    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign acc_cnt = cnt_q;

endmodule

// File: tb/tb_demux_1x4_reg.sv
// Scoreboard bench for demux_1x4_reg: per-lane expected-word queues filled on accept, drained on handshake.
module tb_demux_1x4_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] acc_cnt;
`ifdef DEMUX_RR_EN
    logic [1:0] rr_ptr;
`endif

    demux_1x4_reg_if #(.W(4)) bus ();

    demux_1x4_reg #(
        .W     (4),
        .CNT_W (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
`ifdef DEMUX_RR_EN
        .rr_ptr  (rr_ptr),
`endif
        .acc_cnt (acc_cnt)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] exp_q [4][$];
    logic [7:0] m_cnt = 8'd0;
    logic [1:0] m_ptr = 2'd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: compare lane state, counter and drained words against the model.
    always @(negedge clk) begin
        logic [1:0] lane;
        logic [3:0] exp_w;
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) exp_q[k].delete();
            m_cnt = 8'd0;
            m_ptr = 2'd0;
        end else begin
            for (int k = 0; k < 4; k++)
                check_eq($sformatf("out_valid[%0d]", k), 32'(bus.out_valid[k]), 32'(exp_q[k].size() != 0));
            check_eq("acc_cnt", 32'(acc_cnt), 32'(m_cnt));
`ifdef DEMUX_RR_EN
            check_eq("rr_ptr", 32'(rr_ptr), 32'(m_ptr));
`endif
            for (int k = 0; k < 4; k++) begin
                if (bus.out_valid[k] && bus.out_ready[k] && exp_q[k].size() > 0) begin
                    exp_w = exp_q[k].pop_front();
                    check_eq($sformatf("out_data[%0d]", k), 32'(bus.out_data[k*4 +: 4]), 32'(exp_w));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
`ifdef DEMUX_RR_EN
                lane = m_ptr;
`else
                lane = bus.in_sel;
`endif
                exp_q[lane].push_back(bus.in_data);
                m_cnt = m_cnt + 8'd1;
                m_ptr = m_ptr + 2'd1;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after acceptance with valid still high.
    task automatic send(input logic [1:0] s, input logic [3:0] d, output int waits);
        bus.in_valid = 1'b1;
        bus.in_sel   = s;
        bus.in_data  = d;
        waits        = 0;
        @(negedge clk);
        while (!bus.in_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            check_eq("send_timeout_waits", 32'(waits), 32'd0);
            bus.in_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sel    = 2'd0;
        bus.in_data   = 4'd0;
        bus.out_ready = 4'b0000;
        #1;
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check_eq("rst_out_data", 32'(bus.out_data), 32'h0);
        check_eq("rst_acc_cnt", 32'(acc_cnt), 32'h0);
        for (int s = 0; s < 4; s++) begin
            bus.in_sel = 2'(s);
            #1;
            check_eq($sformatf("rst_in_ready_sel%0d", s), 32'(bus.in_ready), 32'd1);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

`ifndef DEMUX_RR_EN
        // Routing sweep with all consumers ready.
        bus.out_ready = 4'b1111;
        for (int d = 0; d < 16; d++) begin
            send(2'(d % 4), 4'(d), w);
            check_eq("sweep_waits", 32'(w), 32'd0);
        end
        idle();
        check_eq("sweep_acc_cnt", 32'(acc_cnt), 32'd16);
        idle();

        // Backpressure on lane 2.
        bus.out_ready = 4'b1011;
        send(2'd2, 4'hA, w);
        bus.in_sel   = 2'd2;
        bus.in_data  = 4'h5;
        @(negedge clk);
        check_eq("bp_in_ready_stalled", 32'(bus.in_ready), 32'd0);
        check_eq("bp_lane2_hold", 32'(bus.out_data[11:8]), 32'hA);
        bus.in_valid = 1'b0;
        for (int s = 0; s < 4; s++) begin
            bus.in_sel = 2'(s);
            #1;
            check_eq($sformatf("bp_in_ready_noval_sel%0d", s), 32'(bus.in_ready), 32'(s != 2));
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd2;
        bus.in_data   = 4'h5;
        bus.out_ready = 4'b1111;
        @(negedge clk);
        check_eq("bp_in_ready_drain", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b0000;
        @(negedge clk);
        check_eq("bp_lane2_valid_kept", 32'(bus.out_valid[2]), 32'd1);
        check_eq("bp_lane2_new_word", 32'(bus.out_data[11:8]), 32'h5);
        @(posedge clk);
        #1;
        bus.out_ready = 4'b1111;
        idle();

        // Lane 1 stalled while lanes 0 and 3 stream.
        bus.out_ready = 4'b1101;
        send(2'd1, 4'h7, w);
        for (int i = 0; i < 6; i++) begin
            send((i % 2) ? 2'd3 : 2'd0, 4'(i + 8), w);
            check_eq("indep_waits", 32'(w), 32'd0);
        end
        idle();
        check_eq("indep_lane1_data", 32'(bus.out_data[7:4]), 32'h7);
        check_eq("indep_lane1_valid", 32'(bus.out_valid[1]), 32'd1);
        bus.out_ready = 4'b1111;
        idle();

        // Async reset between edges with lanes 0 and 3 full.
        bus.out_ready = 4'b0000;
        send(2'd0, 4'h1, w);
        send(2'd3, 4'h2, w);
        idle();
        check_eq("areset_pre_valid", 32'(bus.out_valid), 32'b1001);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("areset_out_valid", 32'(bus.out_valid), 32'h0);
        check_eq("areset_acc_cnt", 32'(acc_cnt), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 4'b1111;
        send(2'd1, 4'h9, w);
        check_eq("areset_first_accept_waits", 32'(w), 32'd0);
        idle();
        check_eq("areset_first_word", 32'(bus.out_data[7:4]), 32'h9);
        check_eq("areset_acc_cnt_after", 32'(acc_cnt), 32'd1);
`else
        // Round-robin: in_sel held at 3, words land on lanes 0,1,2,3,0.
        bus.out_ready = 4'b0000;
        for (int i = 0; i < 4; i++) send(2'd3, 4'(i + 1), w);
        idle();
        check_eq("rr_lanes_full", 32'(bus.out_valid), 32'hF);
        check_eq("rr_lane_data", 32'(bus.out_data), 32'h4321);
        bus.out_ready = 4'b1111;
        send(2'd3, 4'h5, w);
        idle();
        check_eq("rr_lane0_wrap", 32'(bus.out_data[3:0]), 32'h5);
        check_eq("rr_ptr_after5", 32'(rr_ptr), 32'd1);
        idle();
`endif

        // Counter wrap after 256 accepts from a fresh reset.
        do_reset();
        bus.out_ready = 4'b1111;
        for (int i = 0; i < 256; i++) send(2'(i % 4), 4'(i), w);
        idle();
        check_eq("wrap_acc_cnt", 32'(acc_cnt), 32'd0);
        repeat (2) idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
